branch_predictor_gshare_spec: RTL

Parametrised gshare branch predictor with speculative global history, an in-flight prediction queue and misprediction recovery. It sits behind `branch_controller` in place of the non-speculative global predictor and keeps the same request/feedback port set. It adds three behaviours:
- the GHR is updated at prediction time rather than at resolution;
- the PHT is trained at the exact index used for the prediction;
- history is repaired on a mispredict or flush.

---
 rtl/branch_predictor_gshare_spec_pkg.sv | 37 +++
 rtl/branch_predictor_gshare_spec_if.sv | 46 ++++
 rtl/branch_predictor_gshare_spec_bp_inflight_fifo.sv | 73 +++++++
 rtl/branch_predictor_gshare_spec.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_spec_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare_spec_pkg
// Shared types for the speculative gshare predictor and its in-flight queue:
//   - ADDR_WIDTH and the predictor parameter defaults
//   - BranchOutcome: the one-bit taken / not-taken enum used on every port
//   - bp_inflight_t: one queued prediction {index, prediction[, pc]}
// Optional feature macro: BP_STATS_EN adds the branch PC to each queue entry
// so that feedback can be cross-checked against the request that made it.
// ---------------------------------------------------------------------------
package branch_predictor_gshare_spec_pkg;

  localparam int ADDR_WIDTH            = 32;
  localparam int BP_HIST_BITS_DEF      = 9;
  localparam int BP_CTR_BITS_DEF       = 2;
  localparam int BP_PC_OFFSET_DEF      = 2;
  localparam int BP_INFLIGHT_DEPTH_DEF = 4;
  localparam int BP_CTR_INIT_DEF       = 1;

  // Queue entries carry the PHT index at this fixed width so that the queue
  // type does not depend on the predictor instance; HIST_BITS must not
  // exceed it.
  localparam int BP_MAX_HIST_BITS = 16;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [BP_MAX_HIST_BITS-1:0] index;
    BranchOutcome                prediction;
`ifdef BP_STATS_EN
    logic [ADDR_WIDTH-1:0]       pc;
`endif
  } bp_inflight_t;

endpackage

// File: rtl/branch_predictor_gshare_spec_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare_spec_if
// Request / feedback bundle between branch_controller (master) and the
// gshare predictor (slave).
//   request : i_req_valid, i_req_advance, i_req_pc, i_req_target
//             -> o_req_prediction, o_req_stall
//   feedback: i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome, i_flush
//             -> o_fb_orphan
//   stats   : o_stat_branches, o_stat_mispredicts (zero unless BP_STATS_EN)
// Signal names keep the predictor's point of view (i_ = into the predictor).
// ---------------------------------------------------------------------------
interface branch_predictor_gshare_spec_if;
  import branch_predictor_gshare_spec_pkg::*;

  logic                  i_req_valid;
  logic                  i_req_advance;
  logic [ADDR_WIDTH-1:0] i_req_pc;
  logic [ADDR_WIDTH-1:0] i_req_target;
  BranchOutcome          o_req_prediction;
  logic                  o_req_stall;

  logic                  i_fb_valid;
  logic [ADDR_WIDTH-1:0] i_fb_pc;
  BranchOutcome          i_fb_prediction;
  BranchOutcome          i_fb_outcome;
  logic                  i_flush;
  logic                  o_fb_orphan;

  logic [31:0]           o_stat_branches;
  logic [31:0]           o_stat_mispredicts;

  modport master (
    output i_req_valid, i_req_advance, i_req_pc, i_req_target,
    output i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome, i_flush,
    input  o_req_prediction, o_req_stall, o_fb_orphan,
    input  o_stat_branches, o_stat_mispredicts
  );

  modport slave (
    input  i_req_valid, i_req_advance, i_req_pc, i_req_target,
    input  i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome, i_flush,
    output o_req_prediction, o_req_stall, o_fb_orphan,
    output o_stat_branches, o_stat_mispredicts
  );

endinterface

// File: rtl/branch_predictor_gshare_spec_bp_inflight_fifo.sv
// ---------------------------------------------------------------------------
// bp_inflight_fifo
// Small circular queue holding predictions that have been issued but not yet
// resolved.  Push, pop and clear are synchronous; clear wins over both.
// A push while full or a pop while empty is ignored.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   i_push/i_data: enqueue
//   i_pop        : dequeue head (o_head is the current head, valid if !empty)
//   i_clear      : discard every entry
//   o_full/o_empty/o_count: occupancy
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module bp_inflight_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output T                         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only: it is never read while the queue is empty, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/branch_predictor_gshare_spec.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare_spec
// Gshare conditional-branch predictor with speculative global history.
//   - The PHT (2**HIST_BITS saturating counters) is indexed by
//     spec_ghr ^ PC[HIST_BITS+PC_OFFSET-1 -: HIST_BITS]; the prediction is
//     the counter MSB, combinational in the request cycle.
//   - A committed prediction (valid & advance & !stall) is queued together
//     with its index and shifted into spec_ghr immediately.
//   - Feedback pops the oldest prediction, trains the counter at the very
//     index it was predicted from, and shifts the outcome into arch_ghr.
//   - A mispredict or flush discards the queue and rebuilds spec_ghr from
//     the (just updated) arch_ghr.
// Ports: clk, rst_n (asynchronous, active-low) and the slave side of
// branch_predictor_gshare_spec_if (request, feedback, flush, orphan, stats).
// Optional feature macro: BP_STATS_EN enables the branch / mispredict
// counters and a simulation check of feedback PC against the queued PC;
// without it the stats outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_predictor_gshare_spec
  import branch_predictor_gshare_spec_pkg::*;
#(
  parameter int HIST_BITS      = BP_HIST_BITS_DEF,
  parameter int CTR_BITS       = BP_CTR_BITS_DEF,
  parameter int PC_OFFSET      = BP_PC_OFFSET_DEF,
  parameter int INFLIGHT_DEPTH = BP_INFLIGHT_DEPTH_DEF,
  parameter int CTR_INIT       = BP_CTR_INIT_DEF
) (
  input logic                         clk,
  input logic                         rst_n,
  branch_predictor_gshare_spec_if.slave bp
);

  localparam int PHT_SIZE = 1 << HIST_BITS;
  localparam int CNT_W    = $clog2(INFLIGHT_DEPTH) + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  function automatic logic [CTR_BITS-1:0] ctr_update(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)      ? ctr : ctr - 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [HIST_BITS-1:0] r_spec_ghr;
  logic [HIST_BITS-1:0] r_arch_ghr;
  logic [HIST_BITS-1:0] w_arch_ghr_nxt;
  logic [CTR_BITS-1:0]  r_pht [PHT_SIZE];
  logic                 r_fb_orphan;

  logic [HIST_BITS-1:0] w_pc_hash;
  logic [HIST_BITS-1:0] w_idx;
  logic                 w_pred_taken;
  bp_inflight_t         w_push_entry;

  bp_inflight_t         w_q_head;
  logic                 w_q_full;
  logic                 w_q_empty;
  logic [CNT_W-1:0]     w_q_count;
  logic [HIST_BITS-1:0] w_head_idx;

  logic                 w_fb_taken;
  logic                 w_pop;
  logic                 w_mispredict;
  logic                 w_clear;
  logic                 w_push;
  logic                 w_unused;

  // Request: index hash and combinational prediction
  assign w_pc_hash    = bp.i_req_pc[HIST_BITS+PC_OFFSET-1 -: HIST_BITS];
  assign w_idx        = r_spec_ghr ^ w_pc_hash;
  assign w_pred_taken = r_pht[w_idx][CTR_BITS-1];

  assign bp.o_req_prediction = w_pred_taken ? TAKEN : NOT_TAKEN;
  // Stall is purely the registered occupancy; a same-cycle pop does not
  // open a slot for a push.
  assign bp.o_req_stall      = w_q_full;

  always_comb begin
    w_push_entry            = '0;
    w_push_entry.index      = BP_MAX_HIST_BITS'(w_idx);
    w_push_entry.prediction = w_pred_taken ? TAKEN : NOT_TAKEN;
`ifdef BP_STATS_EN
    w_push_entry.pc         = bp.i_req_pc;
`endif
  end

  // Feedback: resolve the head entry; X/Z outcomes count as not-taken
  assign w_fb_taken   = (bp.i_fb_outcome === TAKEN);
  assign w_pop        = bp.i_fb_valid & ~w_q_empty;
  assign w_head_idx   = w_q_head.index[HIST_BITS-1:0];
  assign w_mispredict = w_pop & (w_fb_taken != (w_q_head.prediction == TAKEN));
  // Everything behind a mispredicted branch is wrong-path, as is everything
  // in flight at a redirect; a push in that cycle is wrong-path too.
  assign w_clear      = bp.i_flush | w_mispredict;
  assign w_push       = bp.i_req_valid & bp.i_req_advance & ~w_q_full & ~w_clear;

  assign w_arch_ghr_nxt = w_pop ? {r_arch_ghr[HIST_BITS-2:0], w_fb_taken}
                                : r_arch_ghr;

  bp_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .T     (bp_inflight_t)
  ) u_inflight (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .o_head  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // State update: histories
  // On recovery spec_ghr takes the post-pop arch_ghr, which for a mispredict
  // is exactly {arch_ghr, outcome} and for flush+pop includes the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_ghr <= '0;
      r_arch_ghr <= '0;
    end else begin
      r_arch_ghr <= w_arch_ghr_nxt;
      if (w_clear)
        r_spec_ghr <= w_arch_ghr_nxt;
      else if (w_push)
        r_spec_ghr <= {r_spec_ghr[HIST_BITS-2:0], w_pred_taken};
    end
  end

  // State update: pattern history table, trained at the queued index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_SIZE; i++) r_pht[i] <= CTR_BITS'(CTR_INIT);
    end else if (w_pop) begin
      r_pht[w_head_idx] <= ctr_update(r_pht[w_head_idx], w_fb_taken);
    end
  end

  // Feedback with nothing in flight points at a pipeline bookkeeping bug
  // upstream; it is remembered until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fb_orphan <= 1'b0;
    else if (bp.i_fb_valid && w_q_empty)
      r_fb_orphan <= 1'b1;
  end

  assign bp.o_fb_orphan = r_fb_orphan;

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_pop)        r_stat_branches    <= sat_inc32(r_stat_branches);
      if (w_mispredict) r_stat_mispredicts <= sat_inc32(r_stat_mispredicts);
    end
  end

  assign bp.o_stat_branches    = r_stat_branches;
  assign bp.o_stat_mispredicts = r_stat_mispredicts;

  always @(posedge clk) begin
    if (rst_n && w_pop && (w_q_head.pc != bp.i_fb_pc))
      $error("bp: feedback pc %h does not match queued pc %h",
             bp.i_fb_pc, w_q_head.pc);
  end

  assign w_unused = ^{bp.i_req_target, bp.i_req_pc, bp.i_fb_prediction,
                      w_q_head, w_q_count};
`else
  assign bp.o_stat_branches    = '0;
  assign bp.o_stat_mispredicts = '0;

  assign w_unused = ^{bp.i_req_target, bp.i_req_pc, bp.i_fb_prediction,
                      bp.i_fb_pc, w_q_head, w_q_count, sat_inc32(32'd0)};
`endif

endmodule
